// File: rtl/timer_pkg.sv
// Stopwatch control shared types: state encoding and parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: state_e (IDLE=0, RUN=1, PAUSE=2, LAP=3), default tick divider and
// long-press length, and a helper that tells whether a state is timing.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  // 10 ms tick at 50 MHz; 2 s long press at 50 MHz.
  localparam int unsigned TICK_DIV_DEF    = 500000;
  localparam int unsigned LONG_CYCLES_DEF = 100000000;

  // RUN and LAP both keep the time counter advancing.
  function automatic logic is_running(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/press_detect.sv
// Button press detector: rising-edge event plus a long-press event after a hold.
// Latency: combinational outputs from the current level and registered history.
// Backpressure: none; events are single-cycle and must be consumed when seen.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_i     - debounced button level
//   press_o   - 1 in the first cycle the button reads 1 after reading 0
//   long_o    - 1 in the LONG_CYCLES-th consecutive cycle of a hold, once per hold
module press_detect
  import timer_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic long_o
);

  // One extra count value so the counter can park above the fire point.
  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] FIRE_AT = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] PARKED  = CW'(LONG_CYCLES);

  logic          prev_q;
  logic [CW-1:0] hold_q, hold_d;

  assign press_o = btn_i & ~prev_q;
  // hold_q holds the number of earlier consecutive high cycles, so the
  // current cycle is hold number hold_q+1.
  assign long_o  = btn_i && (hold_q == FIRE_AT);

  // Saturating at PARKED makes the long event fire once; a release re-arms it.
  always_comb begin
    hold_d = hold_q;
    if (!btn_i) begin
      hold_d = '0;
    end else if (hold_q != PARKED) begin
      hold_d = hold_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      hold_q <= '0;
    end else begin
      prev_q <= btn_i;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch controller: start/stop and lap/clear FSM with a tick divider.
// Latency: every output is registered, one cycle after the button event.
// Backpressure: none; pulses are single-cycle and not held for a consumer.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start_btn, lap_btn  - debounced button levels, 1 = pressed
//   tick                - one-cycle pulse every TICK_DIV cycles while timing
//   clear               - one-cycle pulse zeroing the time counter
//   lap_stb             - one-cycle pulse latching the displayed time
//   freeze              - display hold level, 1 exactly while in LAP
//   running             - 1 in RUN or LAP
//   state               - IDLE=0, RUN=1, PAUSE=2, LAP=3
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       lap_btn,
  output logic       tick,
  output logic       clear,
  output logic       lap_stb,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  logic start_ev, lap_ev, lap_long;
  logic start_long_unused;

  press_detect #(.LONG_CYCLES(LONG_CYCLES)) u_start (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (start_btn),
    .press_o(start_ev),
    .long_o (start_long_unused)
  );

  press_detect #(.LONG_CYCLES(LONG_CYCLES)) u_lap (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (lap_btn),
    .press_o(lap_ev),
    .long_o (lap_long)
  );

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          lap_stb_q, lap_stb_d;
  logic          freeze_q, running_q;

  // Priority: long press, then start, then short lap.
  always_comb begin
    state_d   = state_q;
    clear_d   = 1'b0;
    lap_stb_d = 1'b0;
    if (lap_long) begin
      state_d = ST_IDLE;
      clear_d = 1'b1;
    end else if (start_ev) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_LAP:   state_d = ST_PAUSE;
      endcase
    end else if (lap_ev) begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN: begin
          state_d   = ST_LAP;
          lap_stb_d = 1'b1;
        end
        ST_PAUSE: begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
        ST_LAP:   state_d = ST_RUN;
      endcase
    end
  end

  // Divider advances on cycles spent in RUN/LAP. If timing stops exactly at
  // the wrap point, the count parks at DIV_MAX so the owed tick is issued on
  // the first cycle after resuming instead of leaking into PAUSE.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (state_d == ST_IDLE) begin
      div_d = '0;
    end else if (is_running(state_q)) begin
      if (div_q == DIV_MAX) begin
        if (is_running(state_d)) begin
          div_d  = '0;
          tick_d = 1'b1;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      lap_stb_q <= 1'b0;
      freeze_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      lap_stb_q <= lap_stb_d;
      freeze_q  <= (state_d == ST_LAP);
      running_q <= is_running(state_d);
    end
  end

  assign state   = state_q;
  assign tick    = tick_q;
  assign clear   = clear_q;
  assign lap_stb = lap_stb_q;
  assign freeze  = freeze_q;
  assign running = running_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4, LONG_CYCLES=10.
// Each step drives one cycle of inputs and queues the outputs expected after
// the next rising edge; a monitor compares them on the falling edge.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       tick, clear, lap_stb, freeze, running;
  logic [1:0] state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  timer_ctrl #(.TICK_DIV(4), .LONG_CYCLES(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .lap_btn  (lap_btn),
    .tick     (tick),
    .clear    (clear),
    .lap_stb  (lap_stb),
    .freeze   (freeze),
    .running  (running),
    .state    (state)
  );

  // Expected vector layout: {state[1:0], tick, clear, lap_stb, freeze, running}
  typedef struct {
    int         tgt;
    int         id;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_step = 0;

  task automatic step(input logic r, input logic s, input logic l,
                      input logic [1:0] st, input logic tk, input logic cl,
                      input logic ls);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    start_btn = s;
    lap_btn   = l;
    e.tgt = cyc + 1;
    e.id  = n_step;
    e.exp = {st, tk, cl, ls, (st == 2'd3), (st == 2'd1 || st == 2'd3)};
    sb.push_back(e);
    n_step++;
  endtask

  // Monitor: outputs are presented every cycle, so each queued expectation
  // is consumed on the falling edge of its target cycle.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
        e   = sb.pop_front();
        act = {state, tick, clear, lap_stb, freeze, running};
        n_cmp++;
        if (e.tgt != cyc || act !== e.exp) begin
          n_bad++;
          $display("FAIL step%0d {st,tick,clr,lstb,frz,run}: got %b want %b (cycle %0d, due %0d)",
                   e.id, act, e.exp, cyc, e.tgt);
        end
      end
    end
  end

  initial begin
    // Reset: all outputs low.
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);

    // Start held 3 cycles: one transition to RUN, tick every 4 cycles.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Lap in RUN -> LAP with strobe; lap in LAP -> RUN without strobe.
    step(0, 0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 3, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Pause with divider at 2; resume needs two more counts before tick.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    // Pause exactly at the wrap point: no tick in PAUSE, tick right after resume.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0);

    // Lap in PAUSE -> IDLE with clear; lap in IDLE ignored; divider restarts at 0.
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Lap held 15 cycles from RUN: LAP at onset, IDLE + clear at hold 10.
    step(0, 0, 1, 3, 0, 0, 1);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);

    // Both buttons rise together in RUN: start wins, no strobe.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0, 0);

    // Long press coinciding with a start event: long press wins.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 1);
    step(0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-hold aborts the pending long press.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 1);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
